// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor: BTB entry layout and
// 2-bit saturating counter helpers.
package bp_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t STRONG_NT = 2'b00;
    localparam cnt_t WEAK_NT   = 2'b01;
    localparam cnt_t WEAK_T    = 2'b10;
    localparam cnt_t STRONG_T  = 2'b11;

    // Sized for the smallest index; unused upper tag bits stay zero.
    localparam int TAG_W = 30;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        cnt_t             cnt;
    } btb_entry_t;

    function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
        if (taken) begin
            return (cnt == STRONG_T) ? STRONG_T : cnt_t'(cnt + 2'd1);
        end
        return (cnt == STRONG_NT) ? STRONG_NT : cnt_t'(cnt - 2'd1);
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: one combinational read port, one synchronous
// write port, asynchronous clear.
module btb_array
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IDX_BITS-1:0] rd_idx_i,
    output btb_entry_t          rd_entry_o,
    input  logic                wr_en_i,
    input  logic [IDX_BITS-1:0] wr_idx_i,
    input  btb_entry_t          wr_entry_i
);

    localparam int N_ENT = 1 << IDX_BITS;

    btb_entry_t mem_q [N_ENT];
    btb_entry_t mem_d [N_ENT];

    always_comb begin
        mem_d = mem_q;
        if (wr_en_i) begin
            mem_d[wr_idx_i] = wr_entry_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_ENT; i++) begin
                mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WEAK_NT};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage next-PC predictor: BTB lookup in F, prediction carried into D,
// resolved-PC compare raises predict_miss_o and trains the BTB.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int   IDX_BITS = 4,
    parameter cnt_t CNT_INIT = WEAK_T
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_f_i,
    input  logic        stall_f_i,
    input  logic        stall_d_i,
    input  logic        flush_d_i,
    input  logic        is_branch_d_i,
    input  logic        taken_d_i,
    input  logic [31:0] pc_next_d_i,
    output logic [31:0] predict_pc_o,
    output logic        predict_miss_o,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
);

    logic [IDX_BITS-1:0] idx_f;
    logic [TAG_W-1:0]    tag_f;
    btb_entry_t          ent_f;
    logic                hit_f;

    logic                valid_d, valid_q;
    logic                pred_hit_d, pred_hit_q;
    logic [31:0]         pred_pc_d, pred_pc_q;
    logic [IDX_BITS-1:0] pred_idx_d, pred_idx_q;
    logic [TAG_W-1:0]    pred_tag_d, pred_tag_q;
    btb_entry_t          pred_ent_d, pred_ent_q;

    logic [31:0]         hit_cnt_d, hit_cnt_q;
    logic [31:0]         miss_cnt_d, miss_cnt_q;

    logic                upd;
    logic                wr_en;
    btb_entry_t          wr_entry;

    // Fetch stalls do not gate lookup; fetch simply ignores the result.
    logic unused_stall_f;
    assign unused_stall_f = stall_f_i;

    assign idx_f = pc_f_i[IDX_BITS+1:2];
    assign tag_f = TAG_W'(pc_f_i[31:IDX_BITS+2]);
    assign hit_f = ent_f.valid && (ent_f.tag == tag_f);
    assign predict_pc_o = (hit_f && ent_f.cnt[1]) ? ent_f.target : pc_f_i + 32'd4;

    btb_array #(.IDX_BITS(IDX_BITS)) u_btb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_idx_i   (idx_f),
        .rd_entry_o (ent_f),
        .wr_en_i    (wr_en),
        .wr_idx_i   (pred_idx_q),
        .wr_entry_i (wr_entry)
    );

    always_comb begin
        valid_d    = valid_q;
        pred_hit_d = pred_hit_q;
        pred_pc_d  = pred_pc_q;
        pred_idx_d = pred_idx_q;
        pred_tag_d = pred_tag_q;
        pred_ent_d = pred_ent_q;
        if (flush_d_i) begin
            valid_d = 1'b0;
        end else if (!stall_d_i) begin
            valid_d    = 1'b1;
            pred_hit_d = hit_f;
            pred_pc_d  = predict_pc_o;
            pred_idx_d = idx_f;
            pred_tag_d = tag_f;
            pred_ent_d = ent_f;
        end
    end

    assign upd            = valid_q && !stall_d_i;
    assign predict_miss_o = upd && (pc_next_d_i != pred_pc_q);

    // Training starts from the entry as seen at lookup time (no bypass), so
    // every write rewrites the whole entry from that snapshot.
    always_comb begin
        wr_en      = 1'b0;
        wr_entry   = pred_ent_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (upd) begin
            if (is_branch_d_i) begin
                if (predict_miss_o) begin
                    miss_cnt_d = miss_cnt_q + 32'd1;
                end else begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end
                if (pred_hit_q) begin
                    wr_en        = 1'b1;
                    wr_entry.cnt = sat_update(pred_ent_q.cnt, taken_d_i);
                    if (taken_d_i) begin
                        wr_entry.target = pc_next_d_i;
                    end
                end else if (taken_d_i) begin
                    wr_en    = 1'b1;
                    wr_entry = '{valid: 1'b1, tag: pred_tag_q, target: pc_next_d_i, cnt: CNT_INIT};
                end
            end else if (pred_hit_q) begin
                wr_en          = 1'b1;
                wr_entry.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            pred_hit_q <= 1'b0;
            pred_pc_q  <= '0;
            pred_idx_q <= '0;
            pred_tag_q <= '0;
            pred_ent_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            pred_hit_q <= pred_hit_d;
            pred_pc_q  <= pred_pc_d;
            pred_idx_q <= pred_idx_d;
            pred_tag_q <= pred_tag_d;
            pred_ent_q <= pred_ent_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: each pass puts one instruction through
// F and D with the decode register flushed in between.
module tb_branch_predictor;

    localparam logic [31:0] FILL = 32'h0040_0800;
    localparam logic [31:0] PC_B = 32'h0040_0010;
    localparam logic [31:0] PC_J = 32'h0040_0020;
    localparam logic [31:0] PC_N = 32'h0040_1010;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_f_i;
    logic        stall_f_i;
    logic        stall_d_i;
    logic        flush_d_i;
    logic        is_branch_d_i;
    logic        taken_d_i;
    logic [31:0] pc_next_d_i;
    logic [31:0] predict_pc_o;
    logic        predict_miss_o;
    logic [31:0] hit_count_o;
    logic [31:0] miss_count_o;

    int checks_cnt = 0;
    int errors_cnt = 0;

    branch_predictor #(.IDX_BITS(4), .CNT_INIT(2'b10)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pc_f_i         (pc_f_i),
        .stall_f_i      (stall_f_i),
        .stall_d_i      (stall_d_i),
        .flush_d_i      (flush_d_i),
        .is_branch_d_i  (is_branch_d_i),
        .taken_d_i      (taken_d_i),
        .pc_next_d_i    (pc_next_d_i),
        .predict_pc_o   (predict_pc_o),
        .predict_miss_o (predict_miss_o),
        .hit_count_o    (hit_count_o),
        .miss_count_o   (miss_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic run_pass(input string tag, input logic [31:0] pc, input logic br,
                            input logic tk, input logic [31:0] nxt,
                            input logic [31:0] e_pred, input logic [31:0] e_miss,
                            input logic [31:0] e_hit, input logic [31:0] e_mcnt);
        @(negedge clk_i);
        pc_f_i        = pc;
        flush_d_i     = 1'b0;
        is_branch_d_i = 1'b0;
        #1 chk({tag, "_pred"}, predict_pc_o, e_pred);
        @(negedge clk_i);
        pc_f_i        = FILL;
        flush_d_i     = 1'b1;
        is_branch_d_i = br;
        taken_d_i     = tk;
        pc_next_d_i   = nxt;
        #1 chk({tag, "_miss"}, {31'b0, predict_miss_o}, e_miss);
        @(negedge clk_i);
        is_branch_d_i = 1'b0;
        #1;
        chk({tag, "_hcnt"}, hit_count_o, e_hit);
        chk({tag, "_mcnt"}, miss_count_o, e_mcnt);
    endtask

    initial begin
        rst_i         = 1'b1;
        pc_f_i        = 32'h0040_0000;
        stall_f_i     = 1'b0;
        stall_d_i     = 1'b0;
        flush_d_i     = 1'b1;
        is_branch_d_i = 1'b0;
        taken_d_i     = 1'b0;
        pc_next_d_i   = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("rst_pred", predict_pc_o, 32'h0040_0004);
        chk("rst_miss", {31'b0, predict_miss_o}, 32'd0);
        chk("rst_hcnt", hit_count_o, 32'd0);
        chk("rst_mcnt", miss_count_o, 32'd0);

        // beq taken: allocate, then strengthen
        run_pass("b1", PC_B, 1, 1, 32'h0040_0040, 32'h0040_0014, 1, 0, 1);
        run_pass("b2", PC_B, 1, 1, 32'h0040_0040, 32'h0040_0040, 0, 1, 1);
        // beq not taken from strong taken: 11 -> 10 -> 01 -> 00
        run_pass("b3", PC_B, 1, 0, 32'h0040_0014, 32'h0040_0040, 1, 1, 2);
        run_pass("b4", PC_B, 1, 0, 32'h0040_0014, 32'h0040_0040, 1, 1, 3);
        run_pass("b5", PC_B, 1, 0, 32'h0040_0014, 32'h0040_0014, 0, 2, 3);
        // jr with a changing target
        run_pass("j1", PC_J, 1, 1, 32'h0040_0100, 32'h0040_0024, 1, 2, 4);
        run_pass("j2", PC_J, 1, 1, 32'h0040_0200, 32'h0040_0100, 1, 2, 5);
        run_pass("j3", PC_J, 1, 1, 32'h0040_0200, 32'h0040_0200, 0, 3, 5);
        // same idx as PC_B, different tag: no hit
        run_pass("n1", PC_N, 0, 0, 32'h0040_1014, 32'h0040_1014, 0, 3, 5);
        // non-branch on a tag-matching taken entry: miss, entry invalidated
        run_pass("a1", PC_J, 0, 0, 32'h0040_0024, 32'h0040_0200, 1, 3, 5);
        run_pass("a2", PC_J, 0, 0, 32'h0040_0024, 32'h0040_0024, 0, 3, 5);

        // decode stall with a mispredicted branch (PC_B entry cnt 00)
        @(negedge clk_i);
        pc_f_i    = PC_B;
        flush_d_i = 1'b0;
        #1 chk("st_pred", predict_pc_o, 32'h0040_0014);
        @(negedge clk_i);
        pc_f_i        = FILL;
        stall_d_i     = 1'b1;
        is_branch_d_i = 1'b1;
        taken_d_i     = 1'b1;
        pc_next_d_i   = 32'h0040_0040;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_miss", {31'b0, predict_miss_o}, 32'd0);
            chk("st_mcnt", miss_count_o, 32'd5);
            chk("st_hcnt", hit_count_o, 32'd3);
            @(negedge clk_i);
        end
        stall_d_i = 1'b0;
        flush_d_i = 1'b1;
        #1 chk("rel_miss", {31'b0, predict_miss_o}, 32'd1);
        @(negedge clk_i);
        is_branch_d_i = 1'b0;
        #1;
        chk("rel_mcnt", miss_count_o, 32'd6);
        chk("rel_hcnt", hit_count_o, 32'd3);
        // a single update moved the counter 00 -> 01
        run_pass("s1", PC_B, 1, 1, 32'h0040_0040, 32'h0040_0014, 1, 3, 7);
        run_pass("s2", PC_B, 1, 1, 32'h0040_0040, 32'h0040_0040, 0, 4, 7);

        // flush together with stall drops the D-stage prediction
        @(negedge clk_i);
        pc_f_i    = PC_B;
        flush_d_i = 1'b0;
        stall_f_i = 1'b1;
        #1 chk("fs_pred", predict_pc_o, 32'h0040_0040);
        @(negedge clk_i);
        pc_f_i        = FILL;
        stall_f_i     = 1'b0;
        stall_d_i     = 1'b1;
        flush_d_i     = 1'b1;
        is_branch_d_i = 1'b1;
        taken_d_i     = 1'b1;
        pc_next_d_i   = 32'h0040_0900;
        #1 chk("fs_miss", {31'b0, predict_miss_o}, 32'd0);
        @(negedge clk_i);
        stall_d_i = 1'b0;
        flush_d_i = 1'b0;
        #1 chk("fs_nomiss", {31'b0, predict_miss_o}, 32'd0);
        @(negedge clk_i);
        flush_d_i     = 1'b1;
        is_branch_d_i = 1'b0;
        pc_next_d_i   = FILL + 32'd4;
        #1;
        chk("fs_hcnt", hit_count_o, 32'd4);
        chk("fs_mcnt", miss_count_o, 32'd7);
        @(negedge clk_i);
        pc_f_i = PC_B;
        #1 chk("fs_keep", predict_pc_o, 32'h0040_0040);

        // asynchronous reset mid-cycle
        #2 rst_i = 1'b1;
        #1;
        chk("ar_pred", predict_pc_o, 32'h0040_0014);
        chk("ar_hcnt", hit_count_o, 32'd0);
        chk("ar_mcnt", miss_count_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
